room_transition_ctrl: RTL and testbench
=======================================

// Module: room_transition_ctrl
// PURPOSE
//  Sequences a room change when the player enters a door: fades the screen out, updates the
//  current room index on a rooms grid, issues a player respawn position, then fades back in.
//  Sits between the collision logic (doorcode source) and the VGA colour mapper and player FSM.
//  Holds game logic frozen for the whole transition.
// PARAMETERS
//  MAP_W        4   rooms per grid row; room = row*MAP_W + col
//  MAP_H        2   rooms per grid column
//  ROOM_W       3   width of room index; MAP_W*MAP_H <= 2**ROOM_W
//  START_ROOM   0   room after reset
//  FADE_FRAMES  2   frame_tick pulses per brightness step (>=1)
// PORTS
//  Clk          in   1       system clock (50 MHz)
//  Reset        in   1       synchronous, active-low reset
//  frame_tick   in   1       one-Clk pulse per frame (vsync edge, generated upstream)
//  doorcode     in   3       0 none, 1 left, 2 right, 3 top, 4 bottom, 5-7 unused
//  room         out  ROOM_W  current room index
//  room_load    out  1       one-Clk pulse when room changes
//  spawn_valid  out  1       one-Clk pulse; spawn_x/y valid this cycle only
//  spawn_x      out  10      player respawn x (pixels)
//  spawn_y      out  10      player respawn y (pixels)
//  brightness   out  4       colour scale for VGA mapper; 15 full, 0 black
//  freeze       out  1       high while any transition is in progress
// BEHAVIOUR
//  Reset (Reset==0 at Clk edge): room=START_ROOM, brightness=15, freeze=0, room_load=0,
//   spawn_valid=0, spawn_x=320, spawn_y=240, state=IDLE, frame counter=0. Applies mid-transition too.
//  States: IDLE -> FADE_OUT -> LOAD -> SPAWN -> FADE_IN -> IDLE.
//  IDLE: doorcode sampled each Clk. Door is legal if 1..4 and destination is on grid:
//   left col>0 (room-1), right col<MAP_W-1 (room+1), top row>0 (room-MAP_W),
//   bottom row<MAP_H-1 (room+MAP_W). Legal door: latch door and destination, go FADE_OUT next
//   cycle, freeze=1 from that cycle. Illegal door or 5-7: ignored, stay IDLE, no outputs change.
//   A frame_tick coinciding with the detection cycle is not counted.
//  FADE_OUT: count frame_ticks; every FADE_FRAMES-th tick brightness decrements by 1; on the tick
//   that makes brightness 0, go LOAD. Duration 15*FADE_FRAMES ticks. doorcode ignored.
//  LOAD (1 Clk): room <= latched destination, room_load=1.
//  SPAWN (1 Clk): spawn_valid=1; coordinates by entry door: right->(32,240), left->(592,240),
//   bottom->(320,32), top->(320,432); i.e. player appears at opposite wall.
//  FADE_IN: mirror of FADE_OUT, brightness increments; tick reaching 15 returns to IDLE with
//   freeze=0 the following cycle. Frame counter cleared on every state entry.
//  freeze=1 in all states except IDLE. brightness saturates (never wraps) in both fades.
//  Any doorcode held across return to IDLE starts a new transition (upstream must clear it
//   once player is respawned; spawn positions are outside door zones).
//  Arithmetic: col = room % MAP_W, row = room / MAP_W computed in room_nav; no wrap across edges.
// STRUCTURE
//  room_pkg: door_t enum (DOOR_NONE..DOOR_BOTTOM), xfer_state_t enum, spawn constants
//   (SPAWN_L_X=32, SPAWN_R_X=592, SPAWN_T_Y=32, SPAWN_B_Y=432, CENTER_X=320, CENTER_Y=240).
//  Sub-module room_nav: combinational (room, doorcode) -> (legal, dest_room, spawn_x, spawn_y).
//  Top: FSM, frame counter, brightness register, output registers.
// TESTING (MAP_W=4, MAP_H=2, FADE_FRAMES=1 unless noted)
//  1 Reset released -> room=0, brightness=15, freeze=0, room_load=0, spawn_valid=0.
//  2 room 0, doorcode=2 one Clk -> freeze=1 next Clk; brightness 14..0 over 15 ticks; room_load
//    pulse with room=1; spawn_valid with (32,240); 15 ticks later brightness=15, freeze=0.
//  3 room 0: doorcode=1, then 3, then 6 -> no transition, freeze stays 0, room stays 0.
//  4 room 1, doorcode=4 -> room=5, spawn (320,32); then doorcode=3 -> room=1, spawn (320,432).
//  5 Reset asserted during FADE_OUT at brightness 8 -> next Clk brightness=15, room=0, freeze=0.
//  6 FADE_FRAMES=3, door 2 in room 0, doorcode switched to 4 mid-fade -> destination stays 1;
//    brightness steps every 3rd tick, total 45 ticks out.

Source files
------------

// File: rtl/room_pkg.sv
// rtl/room_pkg.sv - shared types and constants for the room transition controller
package room_pkg;

    typedef enum logic [2:0] {
        DOOR_NONE   = 3'd0,
        DOOR_LEFT   = 3'd1,
        DOOR_RIGHT  = 3'd2,
        DOOR_TOP    = 3'd3,
        DOOR_BOTTOM = 3'd4
    } door_t;

    typedef enum logic [2:0] {
        XFER_IDLE,
        XFER_FADE_OUT,
        XFER_LOAD,
        XFER_SPAWN,
        XFER_FADE_IN
    } xfer_state_t;

    localparam logic [9:0] SPAWN_L_X = 10'd32;
    localparam logic [9:0] SPAWN_R_X = 10'd592;
    localparam logic [9:0] SPAWN_T_Y = 10'd32;
    localparam logic [9:0] SPAWN_B_Y = 10'd432;
    localparam logic [9:0] CENTER_X  = 10'd320;
    localparam logic [9:0] CENTER_Y  = 10'd240;

    localparam logic [3:0] BRIGHT_FULL  = 4'd15;
    localparam logic [3:0] BRIGHT_BLACK = 4'd0;

endpackage

// File: rtl/room_nav.sv
// rtl/room_nav.sv - door legality, destination room and respawn point on the rooms grid
module room_nav #(
    parameter int MAP_W  = 4,
    parameter int MAP_H  = 2,
    parameter int ROOM_W = 3
) (
    input  logic [ROOM_W-1:0] room,
    input  logic [2:0]        doorcode,
    output logic              legal,
    output logic [ROOM_W-1:0] dest_room,
    output logic [9:0]        spawn_x,
    output logic [9:0]        spawn_y
);
    import room_pkg::*;

    localparam logic [ROOM_W-1:0] STEP_COL = ROOM_W'(1);
    localparam logic [ROOM_W-1:0] STEP_ROW = ROOM_W'(MAP_W);

    int col_i;
    int row_i;

    // Grid position of the room, edge checks, and the opposite-wall respawn point
    always_comb begin
        col_i     = int'(room) % MAP_W;
        row_i     = int'(room) / MAP_W;
        legal     = 1'b0;
        dest_room = room;
        spawn_x   = CENTER_X;
        spawn_y   = CENTER_Y;
        case (doorcode)
            DOOR_LEFT: begin
                spawn_x = SPAWN_R_X;
                if (col_i > 0) begin
                    legal     = 1'b1;
                    dest_room = room - STEP_COL;
                end
            end
            DOOR_RIGHT: begin
                spawn_x = SPAWN_L_X;
                if (col_i < MAP_W - 1) begin
                    legal     = 1'b1;
                    dest_room = room + STEP_COL;
                end
            end
            DOOR_TOP: begin
                spawn_y = SPAWN_B_Y;
                if (row_i > 0) begin
                    legal     = 1'b1;
                    dest_room = room - STEP_ROW;
                end
            end
            DOOR_BOTTOM: begin
                spawn_y = SPAWN_T_Y;
                if (row_i < MAP_H - 1) begin
                    legal     = 1'b1;
                    dest_room = room + STEP_ROW;
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/room_transition_ctrl.sv
// rtl/room_transition_ctrl.sv - fade-out / room load / respawn / fade-in sequencer
module room_transition_ctrl #(
    parameter int MAP_W       = 4,
    parameter int MAP_H       = 2,
    parameter int ROOM_W      = 3,
    parameter int START_ROOM  = 0,
    parameter int FADE_FRAMES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic [2:0]        doorcode,
    output logic [ROOM_W-1:0] room,
    output logic              room_load,
    output logic              spawn_valid,
    output logic [9:0]        spawn_x,
    output logic [9:0]        spawn_y,
    output logic [3:0]        brightness,
    output logic              freeze
);
    import room_pkg::*;

    localparam int              CNT_W    = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);

    xfer_state_t       state;
    logic [CNT_W-1:0]  frame_cnt;
    logic [ROOM_W-1:0] dest_q;
    door_t             door_q;

    logic [2:0]        nav_door;
    logic              nav_legal;
    logic [ROOM_W-1:0] nav_dest;
    logic [9:0]        nav_spawn_x;
    logic [9:0]        nav_spawn_y;
    logic              step_tick;

    // In IDLE the navigator judges the live doorcode; afterwards it only supplies the
    // respawn point for the latched door (spawn depends on the door alone).
    assign nav_door  = (state == XFER_IDLE) ? doorcode : door_q;
    assign step_tick = frame_tick && (frame_cnt == CNT_LAST);

    room_nav #(
        .MAP_W  (MAP_W),
        .MAP_H  (MAP_H),
        .ROOM_W (ROOM_W)
    ) u_nav (
        .room      (room),
        .doorcode  (nav_door),
        .legal     (nav_legal),
        .dest_room (nav_dest),
        .spawn_x   (nav_spawn_x),
        .spawn_y   (nav_spawn_y)
    );

    // Transition FSM with frame counter, brightness ramp and registered outputs
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= XFER_IDLE;
            frame_cnt   <= '0;
            dest_q      <= ROOM_W'(START_ROOM);
            door_q      <= DOOR_NONE;
            room        <= ROOM_W'(START_ROOM);
            room_load   <= 1'b0;
            spawn_valid <= 1'b0;
            spawn_x     <= CENTER_X;
            spawn_y     <= CENTER_Y;
            brightness  <= BRIGHT_FULL;
            freeze      <= 1'b0;
        end else begin
            room_load   <= 1'b0;
            spawn_valid <= 1'b0;
            case (state)
                XFER_IDLE: begin
                    if (nav_legal) begin
                        door_q    <= door_t'(doorcode);
                        dest_q    <= nav_dest;
                        frame_cnt <= '0;
                        freeze    <= 1'b1;
                        state     <= XFER_FADE_OUT;
                    end
                end
                XFER_FADE_OUT: begin
                    if (frame_tick) begin
                        if (step_tick) begin
                            frame_cnt <= '0;
                            if (brightness != BRIGHT_BLACK) begin
                                brightness <= brightness - 4'd1;
                            end
                            if (brightness <= 4'd1) begin
                                state <= XFER_LOAD;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end
                XFER_LOAD: begin
                    room      <= dest_q;
                    room_load <= 1'b1;
                    frame_cnt <= '0;
                    state     <= XFER_SPAWN;
                end
                XFER_SPAWN: begin
                    spawn_valid <= 1'b1;
                    spawn_x     <= nav_spawn_x;
                    spawn_y     <= nav_spawn_y;
                    frame_cnt   <= '0;
                    state       <= XFER_FADE_IN;
                end
                XFER_FADE_IN: begin
                    if (frame_tick) begin
                        if (step_tick) begin
                            frame_cnt <= '0;
                            if (brightness != BRIGHT_FULL) begin
                                brightness <= brightness + 4'd1;
                            end
                            if (brightness >= 4'd14) begin
                                freeze <= 1'b0;
                                state  <= XFER_IDLE;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    freeze <= 1'b0;
                    state  <= XFER_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_room_transition_ctrl.sv
// tb/tb_room_transition_ctrl.sv - self-checking bench for room_transition_ctrl
module tb_room_transition_ctrl;

    logic       Clk;
    logic       Reset;

    logic       frame_tick_a;
    logic [2:0] doorcode_a;
    logic [2:0] room_a;
    logic       room_load_a;
    logic       spawn_valid_a;
    logic [9:0] spawn_x_a;
    logic [9:0] spawn_y_a;
    logic [3:0] brightness_a;
    logic       freeze_a;

    logic       frame_tick_b;
    logic [2:0] doorcode_b;
    logic [2:0] room_b;
    logic       room_load_b;
    logic       spawn_valid_b;
    logic [9:0] spawn_x_b;
    logic [9:0] spawn_y_b;
    logic [3:0] brightness_b;
    logic       freeze_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    int exp_room_q[$];
    int exp_sx_q[$];
    int exp_sy_q[$];

    typedef struct {
        logic [2:0] door;
        bit         legal;
        int         dest;
        int         sx;
        int         sy;
    } vec_t;

    vec_t vecs[20];

    room_transition_ctrl #(
        .MAP_W(4), .MAP_H(2), .ROOM_W(3), .START_ROOM(0), .FADE_FRAMES(1)
    ) dut_a (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick_a),
        .doorcode    (doorcode_a),
        .room        (room_a),
        .room_load   (room_load_a),
        .spawn_valid (spawn_valid_a),
        .spawn_x     (spawn_x_a),
        .spawn_y     (spawn_y_a),
        .brightness  (brightness_a),
        .freeze      (freeze_a)
    );

    room_transition_ctrl #(
        .MAP_W(4), .MAP_H(2), .ROOM_W(3), .START_ROOM(0), .FADE_FRAMES(3)
    ) dut_b (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick_b),
        .doorcode    (doorcode_b),
        .room        (room_b),
        .room_load   (room_load_b),
        .spawn_valid (spawn_valid_b),
        .spawn_x     (spawn_x_b),
        .spawn_y     (spawn_y_b),
        .brightness  (brightness_b),
        .freeze      (freeze_b)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Free-running frame tick for dut_a: one pulse every third cycle
    initial begin
        frame_tick_a = 1'b0;
        forever begin
            repeat (2) @(negedge Clk);
            frame_tick_a = 1'b1;
            @(negedge Clk);
            frame_tick_a = 1'b0;
        end
    end

    // Scoreboard for dut_a: room_load and spawn_valid pulses pop expected values
    always @(negedge Clk) begin
        if (mon_en) begin
            if (room_load_a) begin
                if (exp_room_q.size() == 0) begin
                    check("unexpected_room_load", 1, 0);
                end else begin
                    check("room_at_load", room_a, exp_room_q.pop_front());
                end
            end
            if (spawn_valid_a) begin
                if (exp_sx_q.size() == 0) begin
                    check("unexpected_spawn", 1, 0);
                end else begin
                    check("spawn_x", spawn_x_a, exp_sx_q.pop_front());
                    check("spawn_y", spawn_y_a, exp_sy_q.pop_front());
                end
            end
            if (!freeze_a) begin
                check("idle_brightness", brightness_a, 15);
            end
        end
    end

    task automatic tick_b_pulse();
        @(negedge Clk);
        frame_tick_b = 1'b1;
        @(negedge Clk);
        frame_tick_b = 1'b0;
    endtask

    initial begin
        int cnt;
        vec_t v;

        vecs[0]  = '{3'd1, 1'b0, 0, 0, 0};
        vecs[1]  = '{3'd3, 1'b0, 0, 0, 0};
        vecs[2]  = '{3'd6, 1'b0, 0, 0, 0};
        vecs[3]  = '{3'd2, 1'b1, 1, 32, 240};
        vecs[4]  = '{3'd4, 1'b1, 5, 320, 32};
        vecs[5]  = '{3'd3, 1'b1, 1, 320, 432};
        vecs[6]  = '{3'd1, 1'b1, 0, 592, 240};
        vecs[7]  = '{3'd4, 1'b1, 4, 320, 32};
        vecs[8]  = '{3'd1, 1'b0, 4, 0, 0};
        vecs[9]  = '{3'd4, 1'b0, 4, 0, 0};
        vecs[10] = '{3'd0, 1'b0, 4, 0, 0};
        vecs[11] = '{3'd7, 1'b0, 4, 0, 0};
        vecs[12] = '{3'd2, 1'b1, 5, 32, 240};
        vecs[13] = '{3'd2, 1'b1, 6, 32, 240};
        vecs[14] = '{3'd2, 1'b1, 7, 32, 240};
        vecs[15] = '{3'd2, 1'b0, 7, 0, 0};
        vecs[16] = '{3'd4, 1'b0, 7, 0, 0};
        vecs[17] = '{3'd3, 1'b1, 3, 320, 432};
        vecs[18] = '{3'd5, 1'b0, 3, 0, 0};
        vecs[19] = '{3'd1, 1'b1, 2, 592, 240};

        Reset        = 1'b0;
        doorcode_a   = 3'd0;
        doorcode_b   = 3'd0;
        frame_tick_b = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        check("reset_room", room_a, 0);
        check("reset_brightness", brightness_a, 15);
        check("reset_freeze", freeze_a, 0);
        check("reset_room_load", room_load_a, 0);
        check("reset_spawn_valid", spawn_valid_a, 0);
        check("reset_spawn_x", spawn_x_a, 320);
        check("reset_spawn_y", spawn_y_a, 240);
        check("reset_b_brightness", brightness_b, 15);
        mon_en = 1'b1;

        // Table of door requests against dut_a
        for (int i = 0; i < 20; i++) begin
            v = vecs[i];
            @(negedge Clk);
            doorcode_a = v.door;
            if (v.legal) begin
                exp_room_q.push_back(v.dest);
                exp_sx_q.push_back(v.sx);
                exp_sy_q.push_back(v.sy);
            end
            @(negedge Clk);
            doorcode_a = 3'd0;
            check($sformatf("freeze_after_door[%0d]", i), freeze_a, int'(v.legal));
            if (v.legal) begin
                cnt = 0;
                while (freeze_a && cnt < 400) begin
                    @(negedge Clk);
                    cnt++;
                end
                check($sformatf("fade_done[%0d]", i), freeze_a, 0);
                check($sformatf("end_brightness[%0d]", i), brightness_a, 15);
            end
            check($sformatf("room[%0d]", i), room_a, v.dest);
        end
        check("room_q_drained", exp_room_q.size(), 0);
        check("spawn_q_drained", exp_sx_q.size(), 0);

        // dut_b: slow fade, detection-cycle tick ignored, door change mid-fade ignored
        @(negedge Clk);
        doorcode_b   = 3'd2;
        frame_tick_b = 1'b1;
        @(negedge Clk);
        doorcode_b   = 3'd0;
        frame_tick_b = 1'b0;
        check("b_freeze_rise", freeze_b, 1);
        check("b_detect_tick_ignored", brightness_b, 15);
        tick_b_pulse();
        tick_b_pulse();
        check("b_two_ticks", brightness_b, 15);
        tick_b_pulse();
        check("b_three_ticks", brightness_b, 14);
        cnt = 3;
        for (int k = 0; k < 7; k++) begin
            tick_b_pulse();
            cnt++;
        end
        doorcode_b = 3'd4;
        while (brightness_b != 4'd0 && cnt < 100) begin
            tick_b_pulse();
            cnt++;
        end
        check("b_fade_out_ticks", cnt, 45);
        doorcode_b = 3'd0;
        repeat (3) @(negedge Clk);
        check("b_dest_room", room_b, 1);
        check("b_spawn_x", spawn_x_b, 32);
        check("b_spawn_y", spawn_y_b, 240);
        check("b_black_hold", brightness_b, 0);
        cnt = 0;
        while (freeze_b && cnt < 100) begin
            tick_b_pulse();
            cnt++;
        end
        check("b_fade_in_ticks", cnt, 45);
        check("b_end_brightness", brightness_b, 15);

        // Reset in the middle of a fade-out on dut_a (room 2 heading to 3)
        @(negedge Clk);
        doorcode_a = 3'd2;
        @(negedge Clk);
        doorcode_a = 3'd0;
        cnt = 0;
        while (brightness_a != 4'd8 && cnt < 200) begin
            @(negedge Clk);
            cnt++;
        end
        check("mid_fade_brightness", brightness_a, 8);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        check("midreset_brightness", brightness_a, 15);
        check("midreset_room", room_a, 0);
        check("midreset_freeze", freeze_a, 0);
        check("midreset_room_load", room_load_a, 0);
        repeat (60) @(negedge Clk);
        check("midreset_stays_idle", freeze_a, 0);
        check("midreset_room_hold", room_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
